// File: rtl/spgd_dac_pkg.sv
// Shared types and Q-format constants for the SPGD DAC output chain.
// Input is signed 16Q48 volts, scale is unsigned Q16.16 codes-per-volt.
package spgd_dac_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        STEP   = 2'd2,
        SETTLE = 2'd3
    } dac_state_t;

    localparam int FRAC_BITS  = 48;
    localparam int SCALE_FRAC = 16;
    // Half an LSB of the integer code once both fractions are combined.
    localparam int ROUND_BIT  = FRAC_BITS + SCALE_FRAC - 1;

    localparam int DAC_BITS = 12;
    localparam int DAC_MAX  = (1 << DAC_BITS) - 1;

    function automatic int dac_max_for(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/dac_out_if.sv
// Request/response bundle between the SPGD core and the DAC output block.
// master = core side driving requests, slave = dac_out.
interface dac_out_if #(
    parameter int FLOAT_WIDTH = 64,
    parameter int DAC_WIDTH   = 12
);
    logic [FLOAT_WIDTH-1:0] in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [DAC_WIDTH-1:0]   dac_data;
    logic                   dac_wr;
    logic                   busy;
    logic                   done;

    modport master (
        output in_data, in_valid,
        input  in_ready, dac_data, dac_wr, busy, done
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, dac_data, dac_wr, busy, done
    );
endinterface

// File: rtl/dac_scale_sat.sv
// Purpose: signed 16Q48 volts * Q16.16 scale, round half up, clamp to DAC range.
// Latency: 2 cycles from start to tgt_vld (multiply stage, round/clamp stage).
// Backpressure: none; caller issues start only when it can consume the result.
module dac_scale_sat
    import spgd_dac_pkg::*;
#(
    parameter int          FLOAT_WIDTH = 64,
    parameter int          DAC_WIDTH   = 12,
    parameter logic [31:0] SCALE       = 32'h0333_0000
) (
    input  logic                   dac_clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [FLOAT_WIDTH-1:0] in_data,
    output logic [DAC_WIDTH-1:0]   tgt_code,
    output logic                   tgt_vld
);
    localparam int PW    = FLOAT_WIDTH + 32;
    localparam int SHIFT = FRAC_BITS + SCALE_FRAC;
    localparam int IW    = PW - SHIFT;
    localparam logic [PW-1:0] ROUND_ADD = PW'(1) << ROUND_BIT;
    localparam logic [IW-1:0] CODE_MAX  = IW'(dac_max_for(DAC_WIDTH));

    logic signed [PW-1:0]  prod_q;
    logic                  prod_vld_q;
    logic signed [IW-1:0]  code_int;
    logic [DAC_WIDTH-1:0]  code_sat;

    always_ff @(posedge dac_clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
        end else begin
            prod_vld_q <= start;
            if (start) begin
                prod_q <= $signed({{32{in_data[FLOAT_WIDTH-1]}}, in_data})
                        * $signed({{FLOAT_WIDTH{1'b0}}, SCALE});
            end
        end
    end

    // The product never reaches the top bit, so adding the half-LSB cannot overflow.
    assign code_int = IW'($signed(prod_q + ROUND_ADD) >>> SHIFT);

    always_comb begin
        code_sat = code_int[DAC_WIDTH-1:0];
        if (code_int[IW-1]) begin
            code_sat = '0;
        end else if (code_int > $signed(CODE_MAX)) begin
            code_sat = '1;
        end
    end

    always_ff @(posedge dac_clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_code <= '0;
            tgt_vld  <= 1'b0;
        end else begin
            tgt_vld <= prod_vld_q;
            if (prod_vld_q) begin
                tgt_code <= code_sat;
            end
        end
    end

endmodule

// File: rtl/dac_out.sv
// Purpose: convert a 16Q48 volt request to a DAC code, write it (slew-limited under DAC_SLEW_LIMIT_EN), settle, pulse done.
// Latency: first dac_wr in the cycle after edge T+3; done SETTLE_CYCLES+1 cycles after the last write.
// Backpressure: in_ready only while idle; requests presented while busy are ignored, never queued.
module dac_out
    import spgd_dac_pkg::*;
#(
    parameter int                   FLOAT_WIDTH   = 64,
    parameter int                   DAC_WIDTH     = 12,
    parameter logic [31:0]          SCALE         = 32'h0333_0000,
    parameter logic [DAC_WIDTH-1:0] RESET_CODE    = 12'd2048,
    parameter int                   MAX_STEP      = 256,
    parameter int                   SETTLE_CYCLES = 1023
) (
    input  logic      dac_clk,
    input  logic      rst_n,
    dac_out_if.slave  bus
);
    localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES);

    dac_state_t           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DAC_WIDTH-1:0] dac_q, dac_d;
    logic                 wr_q, wr_d;
    logic                 done_q, done_d;

    logic                 start;
    logic [DAC_WIDTH-1:0] tgt_code;
    logic                 tgt_vld;
    logic [DAC_WIDTH-1:0] next_code;

    assign bus.in_ready = (state_q == IDLE);
    assign bus.busy     = (state_q != IDLE);
    assign bus.dac_data = dac_q;
    assign bus.dac_wr   = wr_q;
    assign bus.done     = done_q;
    assign start        = bus.in_valid && (state_q == IDLE);

    dac_scale_sat #(
        .FLOAT_WIDTH (FLOAT_WIDTH),
        .DAC_WIDTH   (DAC_WIDTH),
        .SCALE       (SCALE)
    ) u_scale (
        .dac_clk  (dac_clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_data  (bus.in_data),
        .tgt_code (tgt_code),
        .tgt_vld  (tgt_vld)
    );

`ifdef DAC_SLEW_LIMIT_EN
    localparam logic [DAC_WIDTH:0] STEP_LIM = (DAC_WIDTH + 1)'(MAX_STEP);

    logic [DAC_WIDTH:0] up_gap;
    logic [DAC_WIDTH:0] dn_gap;

    always_comb begin
        up_gap    = {1'b0, tgt_code} - {1'b0, dac_q};
        dn_gap    = {1'b0, dac_q} - {1'b0, tgt_code};
        next_code = tgt_code;
        if (tgt_code > dac_q) begin
            if (up_gap > STEP_LIM) next_code = dac_q + STEP_LIM[DAC_WIDTH-1:0];
        end else if (dn_gap > STEP_LIM) begin
            next_code = dac_q - STEP_LIM[DAC_WIDTH-1:0];
        end
    end
`else
    assign next_code = tgt_code;
`endif

    always_ff @(posedge dac_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dac_q   <= RESET_CODE;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dac_q   <= dac_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dac_d   = dac_q;
        wr_d    = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = CALC;
            end
            CALC: begin
                if (tgt_vld) state_d = STEP;
            end
            STEP: begin
                cnt_d = '0;
                if (dac_q == tgt_code) begin
                    state_d = SETTLE;
                end else begin
                    dac_d = next_code;
                    wr_d  = 1'b1;
                    // Settling starts on the edge of the final write, not one later.
                    if (next_code == tgt_code) state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dac_out.sv
// Randomised self-checking bench for dac_out against a plain arithmetic reference model.
module tb_dac_out;
    localparam int          SC         = 4;
    localparam int          TB_STEP    = 256;
    localparam logic [31:0] TB_SCALE   = 32'h0333_0000;
    localparam int          RESET_VAL  = 2048;
`ifdef DAC_SLEW_LIMIT_EN
    localparam int          SLEW       = TB_STEP;
`else
    localparam int          SLEW       = 1 << 20;
`endif

    logic dac_clk = 1'b0;
    logic rst_n   = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   model_cur = RESET_VAL;

    always #5 dac_clk = ~dac_clk;

    dac_out_if #(.FLOAT_WIDTH(64), .DAC_WIDTH(12)) bus ();

    dac_out #(
        .FLOAT_WIDTH   (64),
        .DAC_WIDTH     (12),
        .SCALE         (TB_SCALE),
        .RESET_CODE    (12'd2048),
        .MAX_STEP      (TB_STEP),
        .SETTLE_CYCLES (SC)
    ) dut (
        .dac_clk (dac_clk),
        .rst_n   (rst_n),
        .bus     (bus.slave)
    );

    function automatic logic [63:0] vq(input int volts);
        logic [63:0] r;
        r = '0;
        r[63:48] = volts[15:0];
        return r;
    endfunction

    // code = floor((v * scale + 2^63) / 2^64), clamped to [0, 4095]
    function automatic int model_code(input logic [63:0] v);
        logic signed [127:0] p;
        p = $signed({{64{v[63]}}, v}) * $signed({96'd0, TB_SCALE});
        p = p + (128'sd1 <<< 63);
        p = p >>> 64;
        if (p[127]) return 0;
        if (p > 128'sd4095) return 4095;
        return int'(p);
    endfunction

    task automatic run_txn(input logic [63:0] v, input logic [63:0] v_hold,
                           input bit hold, input bit presented, input string name);
        int exp_codes[$];
        int got_codes[$];
        int got_k[$];
        int tgt, cur, nw, done_k, exp_done_k;
        bit busy_ok;
        tgt = model_code(v);
        cur = model_cur;
        while (cur != tgt) begin
            int d;
            d = tgt - cur;
            if (d > SLEW) d = SLEW;
            else if (d < -SLEW) d = -SLEW;
            cur = cur + d;
            exp_codes.push_back(cur);
        end
        nw = exp_codes.size();

        if (!presented) begin
            @(negedge dac_clk);
            bus.in_data  = v;
            bus.in_valid = 1'b1;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_before: in_ready=%b expected 1", name, bus.in_ready);
        end
        @(posedge dac_clk);
        @(negedge dac_clk);
        if (hold) bus.in_data = v_hold;
        else      bus.in_valid = 1'b0;
        busy_ok = (bus.busy === 1'b1) && (bus.in_ready === 1'b0);
        done_k = -1;
        for (int k = 1; k <= 5000 && done_k < 0; k++) begin
            @(posedge dac_clk);
            @(negedge dac_clk);
            if (bus.dac_wr === 1'b1) begin
                got_codes.push_back(int'(bus.dac_data));
                got_k.push_back(k);
            end
            if (bus.done === 1'b1) done_k = k;
            else if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) busy_ok = 1'b0;
        end

        checks++;
        if (done_k < 0) begin
            failures++;
            $display("FAIL %s done_timeout: done not seen within 5000 cycles", name);
        end
        checks++;
        if (!busy_ok) begin
            failures++;
            $display("FAIL %s busy_window: busy/in_ready wrong between accept and done", name);
        end
        checks++;
        if (got_codes.size() != nw) begin
            failures++;
            $display("FAIL %s write_count: got %0d writes expected %0d", name, got_codes.size(), nw);
        end
        for (int i = 0; i < nw && i < got_codes.size(); i++) begin
            checks++;
            if (got_codes[i] != exp_codes[i]) begin
                failures++;
                $display("FAIL %s write_code[%0d]: dac_data=%0d expected %0d", name, i, got_codes[i], exp_codes[i]);
            end
        end
        if (nw > 0 && got_k.size() == nw) begin
            checks++;
            if (got_k[0] != 3 || got_k[nw-1] != 3 + nw - 1) begin
                failures++;
                $display("FAIL %s write_timing: writes at k=%0d..%0d expected 3..%0d", name, got_k[0], got_k[nw-1], 3 + nw - 1);
            end
        end
        exp_done_k = (nw == 0) ? 4 + SC : 3 + nw + SC;
        checks++;
        if (done_k != exp_done_k) begin
            failures++;
            $display("FAIL %s done_latency: done at k=%0d expected %0d", name, done_k, exp_done_k);
        end
        checks++;
        if (int'(bus.dac_data) != tgt || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s final_state: dac_data=%0d busy=%b in_ready=%b expected %0d 0 1",
                     name, bus.dac_data, bus.busy, bus.in_ready, tgt);
        end
        model_cur = tgt;
        if (!hold) begin
            @(posedge dac_clk);
            @(negedge dac_clk);
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                failures++;
                $display("FAIL %s done_pulse: done=%b busy=%b expected 0 0", name, bus.done, bus.busy);
            end
        end
    endtask

    task automatic test_reset();
        bit quiet;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(negedge dac_clk);
        checks++;
        if (bus.dac_data !== 12'd2048 || bus.dac_wr !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: dac_data=%0d dac_wr=%b done=%b expected 2048 0 0",
                     bus.dac_data, bus.dac_wr, bus.done);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_handshake: busy=%b in_ready=%b expected 0 1", bus.busy, bus.in_ready);
        end
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (6) begin
            @(negedge dac_clk);
            if (bus.dac_wr !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.dac_data !== 12'd2048)
                quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            failures++;
            $display("FAIL reset_release: activity after release, dac_data=%0d expected 2048 idle", bus.dac_data);
        end
    endtask

    task automatic test_convert();
        run_txn(vq(1), '0, 1'b0, 1'b0, "one_volt");
    endtask

    task automatic test_clamp();
        run_txn(vq(-1), '0, 1'b0, 1'b0, "neg_one_volt");
        run_txn(vq(6), '0, 1'b0, 1'b0, "six_volt");
        run_txn(64'h8000_0000_0000_0000, '0, 1'b0, 1'b0, "most_negative");
        run_txn(64'h7FFF_FFFF_FFFF_FFFF, '0, 1'b0, 1'b0, "most_positive");
    endtask

    task automatic test_rounding();
        run_txn(64'h0000_8000_0000_0000, '0, 1'b0, 1'b0, "half_volt");
        run_txn(64'h0001_8000_0000_0000, '0, 1'b0, 1'b0, "one_half_volt");
        run_txn(64'h0001_8000_0000_0000, '0, 1'b0, 1'b0, "same_code");
        run_txn(vq(5), '0, 1'b0, 1'b0, "five_volt");
        run_txn(vq(0), '0, 1'b0, 1'b0, "zero_volt");
    endtask

    task automatic test_back_to_back();
        run_txn(vq(4), '0, 1'b0, 1'b0, "setup_hold");
        run_txn(vq(1), vq(3), 1'b1, 1'b0, "hold_ignored");
        run_txn(vq(3), '0, 1'b0, 1'b1, "after_hold");
    endtask

    task automatic test_reset_mid();
        bit no_done;
        @(negedge dac_clk);
        bus.in_data  = (model_cur > RESET_VAL) ? vq(0) : vq(5);
        bus.in_valid = 1'b1;
        @(posedge dac_clk);
        @(negedge dac_clk);
        bus.in_valid = 1'b0;
        repeat (4) @(posedge dac_clk);
        #2;
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_busy: busy=%b expected 1 before reset", bus.busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.dac_data !== 12'd2048 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1 ||
            bus.dac_wr !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_async: dac_data=%0d busy=%b in_ready=%b wr=%b done=%b expected 2048 0 1 0 0",
                     bus.dac_data, bus.busy, bus.in_ready, bus.dac_wr, bus.done);
        end
        no_done = 1'b1;
        repeat (3) begin
            @(negedge dac_clk);
            if (bus.done !== 1'b0 || bus.dac_wr !== 1'b0) no_done = 1'b0;
        end
        rst_n = 1'b1;
        model_cur = RESET_VAL;
        repeat (2) begin
            @(negedge dac_clk);
            if (bus.done !== 1'b0 || bus.dac_wr !== 1'b0) no_done = 1'b0;
        end
        checks++;
        if (!no_done) begin
            failures++;
            $display("FAIL mid_no_done: done or dac_wr seen after reset, expected none");
        end
        run_txn(vq(2), '0, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            logic [63:0] v;
            int ip;
            ip = int'($urandom_range(0, 14)) - 7;
            v[63:48] = ip[15:0];
            v[47:32] = 16'($urandom());
            v[31:0]  = $urandom();
            run_txn(v, '0, 1'b0, 1'b0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_clamp();
        test_rounding();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
